// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and frame defaults.
// The transmit and receive paths both import this package.
package uart_pkg;

    localparam int DATA_W_DEF     = 8;
    localparam int OVERSAMPLE_DEF = 16;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_state_t;

endpackage

// File: rtl/uart_tx_module.sv
// UART transmitter: 1-deep holding register feeding a shift register.
// Define UART_TX_PARITY_EN to add an even-parity bit before the stop bit.
module uart_tx_module
    import uart_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int OVERSAMPLE = OVERSAMPLE_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tick_16bd,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ack,
    output logic              Tx,
    output logic              busy,
    output logic              frame_done
);

    localparam logic [3:0] LAST_TICK = 4'(OVERSAMPLE - 1);
    localparam logic [2:0] LAST_BIT  = 3'(DATA_W - 1);

    uart_state_t       state;
    logic [3:0]        tick_cnt;
    logic [2:0]        bit_idx;
    logic [DATA_W-1:0] hold_data;
    logic              hold_full;
    logic [DATA_W-1:0] shift;
    logic              tx_q;
`ifdef UART_TX_PARITY_EN
    logic              parity_q;
`endif

    logic last_tick;

    assign last_tick = (tick_cnt == LAST_TICK);
    assign Tx        = tx_q;
    assign busy      = (state != IDLE) || hold_full;

    // Holding-register acceptance plus the frame FSM, advanced only on ticks.
    always_ff @(posedge clk) begin
        tx_ack     <= 1'b0;
        frame_done <= 1'b0;
        if (rst) begin
            state     <= IDLE;
            tx_q      <= 1'b1;
            tick_cnt  <= '0;
            bit_idx   <= '0;
            hold_data <= '0;
            hold_full <= 1'b0;
            shift     <= '0;
`ifdef UART_TX_PARITY_EN
            parity_q  <= 1'b0;
`endif
        end else begin
            // Accept only into an empty holding register; a freeing
            // transfer this cycle still sees it full, so it wins.
            if (tx_valid && !hold_full) begin
                hold_data <= tx_data;
                hold_full <= 1'b1;
                tx_ack    <= 1'b1;
            end
            if (tick_16bd) begin
                unique case (state)
                    IDLE: begin
                        if (hold_full) begin
                            state     <= START;
                            tx_q      <= 1'b0;
                            tick_cnt  <= '0;
                            shift     <= hold_data;
                            hold_full <= 1'b0;
`ifdef UART_TX_PARITY_EN
                            parity_q  <= ^hold_data;
`endif
                        end
                    end
                    START: begin
                        if (last_tick) begin
                            state    <= DATA;
                            tx_q     <= shift[0];
                            tick_cnt <= '0;
                            bit_idx  <= '0;
                        end else begin
                            tick_cnt <= tick_cnt + 4'd1;
                        end
                    end
                    DATA: begin
                        if (last_tick) begin
                            tick_cnt <= '0;
                            if (bit_idx == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
                                state <= PARITY;
                                tx_q  <= parity_q;
`else
                                state <= STOP;
                                tx_q  <= 1'b1;
`endif
                            end else begin
                                shift   <= shift >> 1;
                                tx_q    <= shift[1];
                                bit_idx <= bit_idx + 3'd1;
                            end
                        end else begin
                            tick_cnt <= tick_cnt + 4'd1;
                        end
                    end
`ifdef UART_TX_PARITY_EN
                    PARITY: begin
                        if (last_tick) begin
                            state    <= STOP;
                            tx_q     <= 1'b1;
                            tick_cnt <= '0;
                        end else begin
                            tick_cnt <= tick_cnt + 4'd1;
                        end
                    end
`endif
                    STOP: begin
                        if (last_tick) begin
                            frame_done <= 1'b1;
                            tick_cnt   <= '0;
                            // Chain straight into the next frame when one waits.
                            if (hold_full) begin
                                state     <= START;
                                tx_q      <= 1'b0;
                                shift     <= hold_data;
                                hold_full <= 1'b0;
`ifdef UART_TX_PARITY_EN
                                parity_q  <= ^hold_data;
`endif
                            end else begin
                                state <= IDLE;
                                tx_q  <= 1'b1;
                            end
                        end else begin
                            tick_cnt <= tick_cnt + 4'd1;
                        end
                    end
                    default: begin
                        state    <= IDLE;
                        tx_q     <= 1'b1;
                        tick_cnt <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_module.sv
// Self-checking bench for uart_tx_module: serial monitor + scoreboard.
// Honors UART_TX_PARITY_EN in the same way as the design.
module tb_uart_tx_module;

    localparam int DW = 8;
`ifdef UART_TX_PARITY_EN
    localparam int NB = DW + 3;
`else
    localparam int NB = DW + 2;
`endif
    localparam int BIT_CLK = 64;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          tick_16bd = 1'b0;
    logic [DW-1:0] tx_data = '0;
    logic          tx_valid = 1'b0;
    logic          tx_ack;
    logic          Tx;
    logic          busy;
    logic          frame_done;

    always #5 clk = ~clk;

    uart_tx_module #(.DATA_W(DW), .OVERSAMPLE(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .tick_16bd  (tick_16bd),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ack     (tx_ack),
        .Tx         (Tx),
        .busy       (busy),
        .frame_done (frame_done)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // tick generator: one pulse every 4 clk, frozen while tick_en is low
    logic tick_en = 1'b1;
    int   tcnt = 0;
    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (tick_en) begin
                tick_16bd = (tcnt == 3);
                tcnt = (tcnt + 1) % 4;
            end else begin
                tick_16bd = 1'b0;
            end
        end
    end

    function automatic logic [15:0] frame_of(input logic [DW-1:0] d);
        logic [15:0] w;
        w = '0;
        w[DW:1] = d;
`ifdef UART_TX_PARITY_EN
        w[DW+1] = ^d;
        w[DW+2] = 1'b1;
`else
        w[DW+1] = 1'b1;
`endif
        return w;
    endfunction

    logic [15:0] exp_q[$];
    int          len_q[$];
    bit          b2b_q[$];
    int          edge_q[$];
    int          cyc = 0;
    int          last_edge = 0;
    logic        prev_tx = 1'b1;
    int          mon_act = 0;
    int          mon_ticks = 0;
    int          mon_bits = 0;
    logic [15:0] mon_word = '0;
    int          start_cyc = 0;
    int          done_cnt = 0;
    logic        last_par = 1'b0;
    int          n_sent = 0;

    // serial-line monitor: samples each bit at its middle tick
    always @(negedge clk) begin
        cyc++;
        if (Tx !== prev_tx) begin
            edge_q.push_back(cyc - last_edge);
            last_edge = cyc;
            prev_tx = Tx;
        end
        if (frame_done) begin
            done_cnt++;
            len_q.push_back(cyc - start_cyc);
            b2b_q.push_back(Tx == 1'b0);
        end
        if (rst) begin
            mon_act = 0;
            mon_bits = 0;
        end else if (mon_act == 0) begin
            if (Tx == 1'b0) begin
                mon_act = 1;
                mon_ticks = 0;
                mon_bits = 0;
                mon_word = '0;
                start_cyc = cyc;
            end
        end else if (tick_16bd) begin
            mon_ticks++;
            if (mon_ticks % 16 == 8) begin
                mon_word[mon_bits] = Tx;
                mon_bits++;
                if (mon_bits == NB) begin
                    mon_act = 0;
                    last_par = mon_word[DW+1];
                    if (exp_q.size() == 0)
                        check_eq("sb_unexpected_frame", exp_q.size(), 1);
                    else
                        check_eq("frame_bits", mon_word, exp_q.pop_front());
                end
            end
        end
    end

    task automatic send_byte(input logic [DW-1:0] d);
        bit got;
        got = 1'b0;
        tx_data = d;
        tx_valid = 1'b1;
        for (int i = 0; i < 3000 && !got; i++) begin
            @(posedge clk);
            #1;
            if (tx_ack) got = 1'b1;
        end
        check_eq("ack_seen", got, 1);
        if (got) begin
            exp_q.push_back(frame_of(d));
            n_sent++;
        end
        tx_valid = 1'b0;
        tx_data = DW'($urandom);
    endtask

    task automatic wait_frames(input int target);
        for (int i = 0; i < 5000 && done_cnt < target; i++) begin
            @(posedge clk);
            #1;
        end
        check_eq("frame_wait", done_cnt >= target, 1);
    endtask

    task automatic wait_bits(input int n);
        for (int i = 0; i < 3000 && !(mon_act == 1 && mon_bits == n); i++) begin
            @(posedge clk);
            #1;
        end
        check_eq("bit_wait", mon_bits, n);
    endtask

    task automatic check_len(input string tag, input int exp_len, input bit exp_b2b);
        if (len_q.size() == 0) begin
            check_eq({tag, "_len_missing"}, len_q.size(), 1);
        end else begin
            check_eq({tag, "_len"}, len_q.pop_front(), exp_len);
            check_eq({tag, "_b2b"}, b2b_q.pop_front(), exp_b2b);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int changes;
        logic t0;

        rst = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check_eq("rst_tx", Tx, 1);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_ack", tx_ack, 0);
        check_eq("rst_done", frame_done, 0);
        rst = 1'b0;

        // single 0x55 frame: alternating bits, 64 clk each
        edge_q.delete();
        send_byte(8'h55);
        check_eq("busy_after_ack", busy, 1);
        wait_frames(1);
        check_len("f55", NB * BIT_CLK, 1'b0);
        check_eq("edge_count", edge_q.size() >= 9, 1);
        for (int i = 1; i < 8; i++)
            if (i < edge_q.size())
                check_eq("bit_width", edge_q[i], BIT_CLK);
        repeat (20) @(posedge clk);
        #1;
        check_eq("idle_tx", Tx, 1);
        check_eq("idle_busy", busy, 0);

`ifdef UART_TX_PARITY_EN
        base = done_cnt;
        send_byte(8'h07);
        wait_frames(base + 1);
        check_eq("par_07", last_par, 1);
        check_len("f07", NB * BIT_CLK, 1'b0);
        send_byte(8'h03);
        wait_frames(base + 2);
        check_eq("par_03", last_par, 0);
        check_len("f03", NB * BIT_CLK, 1'b0);
`endif

        // back-to-back frames with no idle gap
        base = done_cnt;
        send_byte(8'hA5);
        send_byte(8'h3C);
        check_eq("ack2_in_frame", done_cnt, base);
        check_eq("ack2_busy", busy, 1);
        wait_frames(base + 2);
        check_len("fA5", NB * BIT_CLK, 1'b1);
        check_len("f3C", NB * BIT_CLK, 1'b0);

        // both registers full: third byte waits for the holding register
        base = done_cnt;
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33);
        check_eq("ack3_after_free", done_cnt, base + 1);
        wait_frames(base + 3);
        check_len("f11", NB * BIT_CLK, 1'b1);
        check_len("f22", NB * BIT_CLK, 1'b1);
        check_len("f33", NB * BIT_CLK, 1'b0);

        // reset in the middle of data bit 3
        base = done_cnt;
        send_byte(8'hF0);
        wait_bits(5);
        check_eq("pre_rst_tx", Tx, 0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_eq("abort_tx", Tx, 1);
        check_eq("abort_busy", busy, 0);
        rst = 1'b0;
        exp_q.delete();
        n_sent--;
        repeat (200) @(posedge clk);
        #1;
        check_eq("abort_no_done", done_cnt, base);
        send_byte(8'h5A);
        wait_frames(base + 1);
        check_len("f5A", NB * BIT_CLK, 1'b0);

        // tick pause mid-frame
        base = done_cnt;
        send_byte(8'h96);
        wait_bits(3);
        tick_en = 1'b0;
        t0 = Tx;
        changes = 0;
        repeat (100) begin
            @(posedge clk);
            #1;
            if (Tx !== t0) changes++;
        end
        tick_en = 1'b1;
        check_eq("pause_tx_stable", changes, 0);
        wait_frames(base + 1);
        check_len("f96", NB * BIT_CLK + 100, 1'b0);

        repeat (20) @(posedge clk);
        #1;
        check_eq("sb_empty", exp_q.size(), 0);
        check_eq("frame_total", done_cnt, n_sent);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_module.md
UART_TX_MODULE -- requirements
Module: uart_tx_module

Interface
REQ-001 SHALL have parameter DATA_W, default 8, meaning data bits per frame.
REQ-002 SHALL have parameter OVERSAMPLE, default 16, meaning baud-tick pulses per serial bit.
REQ-003 SHALL have port clk  input  1  sole system clock; all logic on its rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port tick_16bd  input  1  one-clk-wide enable pulse at 16x baud; not a clock.
REQ-006 SHALL have port tx_data  input  DATA_W  byte to transmit, LSB first.
REQ-007 SHALL have port tx_valid  input  1  tx_data is valid this cycle.
REQ-008 SHALL have port tx_ack  output  1  one-cycle pulse; byte accepted into holding register.
REQ-009 SHALL have port Tx  output  1  serial line, idle high.
REQ-010 SHALL have port busy  output  1  high while a frame is being shifted or the holding register is full.
REQ-011 SHALL have port frame_done  output  1  one-cycle pulse at the end of the stop bit.

Function
REQ-012 SHALL hold one byte in a holding register (1-deep buffer) plus one byte in the shift register.
REQ-013 SHALL pulse tx_ack in the cycle after tx_valid is sampled high while the holding register is empty; otherwise tx_valid is ignored, and the source holds it until tx_ack.
REQ-014 SHALL use FSM states IDLE, START, DATA, PARITY, STOP.
REQ-015 SHALL go IDLE->START on the first tick_16bd with the holding register full, moving the byte to the shift register and freeing the holding register in that cycle.
REQ-016 SHALL make each state last exactly OVERSAMPLE tick_16bd pulses, counted by a 4-bit tick counter that is cleared on every state entry.
REQ-017 SHALL drive Tx=0 in START, Tx=shift[0] in DATA, the parity bit in PARITY, and Tx=1 in STOP and IDLE; Tx SHALL be registered.
REQ-018 SHALL shift right once per DATA bit and count bits with a 3-bit index; after bit DATA_W-1 it goes to PARITY if enabled, else STOP.
REQ-019 SHALL pulse frame_done after the last STOP tick, then go to START on the same tick if the holding register is full (back-to-back, no idle gap), else IDLE.
REQ-020 SHALL give priority to the FSM transfer when tx_valid arrives in the same cycle the holding register is freed; acceptance follows in the next cycle.
REQ-021 SHALL make the frame waveform independent of tx_data changes after acceptance.
REQ-022 SHALL freeze the FSM and counters while tick_16bd is low.

Reset
REQ-023 SHALL on rst set state=IDLE, Tx=1, tx_ack=0, busy=0, frame_done=0, clear the tick and bit counters, and empty the holding register.
REQ-024 SHALL abort a frame when rst is asserted mid-frame: Tx=1 on the next edge and the byte is discarded.

Configuration
REQ-025 SHALL insert one even-parity bit (XOR of the data bits) in PARITY between DATA and STOP when UART_TX_PARITY_EN is defined, giving a 9-bit payload that matches the 9-bit receiver frame.
REQ-026 SHALL exclude the PARITY state and its logic when UART_TX_PARITY_EN is undefined, giving a frame of 1 start, DATA_W data, and 1 stop bit.

Structure
REQ-027 SHALL place the state enum, OVERSAMPLE default and DATA_W default in shared package uart_pkg, reused by the receive path.
REQ-028 SHALL be implemented in a single module with no sub-modules; the tick source stays in clock_handler_module.

Verification
REQ-029 Send 0x55 with parity off, tick every 4 clk -> Tx = 0,1,0,1,0,1,0,1,0,1; each bit lasts 64 clk; frame_done pulses once.
REQ-030 Send 0x07 with UART_TX_PARITY_EN -> parity bit =1; send 0x03 -> parity bit =0; stop bit =1.
REQ-031 Present 0xA5 then 0x3C back-to-back with tx_valid held -> second tx_ack occurs during the first frame; the 0x3C start bit immediately follows the 0xA5 stop bit with no idle high.
REQ-032 Hold tx_valid while both the holding and shift registers are full -> no tx_ack until the holding register is freed; no byte is lost or duplicated.
REQ-033 Assert rst during DATA bit 3 -> next cycle Tx=1, busy=0, state IDLE; the next accepted byte is transmitted intact.
REQ-034 Hold tick_16bd low for 100 clk mid-frame -> Tx constant; the frame resumes with the bit duration unchanged.
